// File: rtl/udp_ts_tx_dma_pkg.sv
// Shared types and constants for the TS frame-buffer transmit DMA.
// Holds the FSM encoding, parameter-word field positions and frame size limit.
package udp_ts_tx_dma_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StUnload,
        StRdParam,
        StWaitParam,
        StRdData,
        StWaitData,
        StDrain,
        StRelease
    } tx_state_e;

    localparam int unsigned LEN_LSB   = 0;
    localparam int unsigned LEN_MSB   = 7;
    localparam int unsigned MAX_WORDS = 47;

    // A frame is unusable if it claims no words or more than one TS packet holds.
    function automatic logic len_bad(input logic [7:0] len, input int unsigned max_words);
        return (len == 8'd0) || (32'(len) > max_words);
    endfunction

endpackage

// File: rtl/udp_ts_tx_out_reg.sv
// Single-entry payload output register with valid/ready handshake.
// Data and framing flags only change on load, so they stay stable while stalled.
module udp_ts_tx_out_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] data_i,
    input  logic        start_i,
    input  logic        end_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] data_o,
    output logic        start_o,
    output logic        end_o
);

    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic        start_q, start_d;
    logic        end_q, end_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        start_d = start_q;
        end_d   = end_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            start_d = start_i;
            end_d   = end_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            start_q <= start_d;
            end_q   <= end_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign start_o = start_q;
    assign end_o   = end_q;

endmodule

// File: rtl/udp_ts_tx_dma.sv
// Transmit DMA: unloads a filled buffer pointer, streams its payload, returns the pointer.
// Define TX_FRAME_COUNT_EN to build the sent/dropped frame counters.
module udp_ts_tx_dma
    import udp_ts_tx_dma_pkg::*;
#(
    parameter int unsigned P_POINTER_WIDTH         = 2,
    parameter int unsigned P_BUFFER_ADDRESS_BITS   = 8,
    parameter int unsigned P_BUFFER_PARAMETER_WORD = 50,
    parameter int unsigned P_MAX_WORDS             = MAX_WORDS
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             unload,
    input  logic [P_POINTER_WIDTH-1:0]       unload_pointer,
    input  logic                             unload_ack,
    output logic [P_POINTER_WIDTH-1:0]       buffer_pointer,
    output logic [P_BUFFER_ADDRESS_BITS-1:0] buffer_address,
    output logic                             buffer_read,
    input  logic [31:0]                      buffer_readdata,
    input  logic                             buffer_readdatavalid,
    input  logic                             buffer_waitrequest,
    output logic                             free,
    output logic [P_POINTER_WIDTH-1:0]       free_pointer,
    input  logic                             free_ack,
    output logic                             payload_out_valid,
    output logic                             payload_out_start,
    output logic                             payload_out_end,
    output logic [31:0]                      payload_out_data,
    input  logic                             payload_out_ready,
    output logic [31:0]                      frame_pap,
    output logic                             length_error,
    output logic [31:0]                      frame_count,
    output logic [31:0]                      drop_count
);

    typedef logic [P_BUFFER_ADDRESS_BITS-1:0] addr_t;
    typedef logic [P_POINTER_WIDTH-1:0]       ptr_t;

    localparam addr_t PARAM_ADDR = addr_t'(P_BUFFER_PARAMETER_WORD);

    tx_state_e state_q, state_d;
    ptr_t      ptr_q, ptr_d;
    addr_t     addr_q, addr_d;
    addr_t     last_q, last_d;
    logic [31:0] pap_q, pap_d;
    logic      lerr_q, lerr_d;

    logic      consume;
    logic      can_issue;
    logic      out_load;
    logic      out_start;
    logic      out_end;

    assign consume = payload_out_valid && payload_out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            addr_q  <= '0;
            last_q  <= '0;
            pap_q   <= '0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            pap_q   <= pap_d;
            lerr_q  <= lerr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        last_d  = last_q;
        pap_d   = pap_q;
        lerr_d  = 1'b0;
        case (state_q)
            StIdle: state_d = StUnload;
            StUnload: begin
                if (unload_ack) begin
                    ptr_d   = unload_pointer;
                    state_d = StRdParam;
                end
            end
            StRdParam: begin
                if (!buffer_waitrequest) state_d = StWaitParam;
            end
            StWaitParam: begin
                if (buffer_readdatavalid) begin
                    pap_d = buffer_readdata;
                    if (len_bad(buffer_readdata[LEN_MSB:LEN_LSB], P_MAX_WORDS)) begin
                        lerr_d  = 1'b1;
                        state_d = StRelease;
                    end else begin
                        addr_d  = '0;
                        last_d  = addr_t'(buffer_readdata[LEN_MSB:LEN_LSB] - 8'd1);
                        state_d = StRdData;
                    end
                end
            end
            StRdData: begin
                if (buffer_read && !buffer_waitrequest) state_d = StWaitData;
            end
            StWaitData: begin
                if (buffer_readdatavalid) begin
                    if (addr_q == last_q) begin
                        state_d = StDrain;
                    end else begin
                        addr_d  = addr_q + addr_t'(1);
                        state_d = StRdData;
                    end
                end
            end
            StDrain: begin
                if (consume) state_d = StRelease;
            end
            StRelease: begin
                if (free_ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // A data read may only be issued when its return word is guaranteed a slot.
    always_comb begin
        can_issue      = !payload_out_valid || consume;
        unload         = (state_q == StUnload);
        buffer_read    = (state_q == StRdParam) || ((state_q == StRdData) && can_issue);
        buffer_address = ((state_q == StRdParam) || (state_q == StWaitParam)) ? PARAM_ADDR
                                                                              : addr_q;
        free           = (state_q == StRelease);
        free_pointer   = free ? ptr_q : '0;
        out_load       = (state_q == StWaitData) && buffer_readdatavalid;
        out_start      = (addr_q == '0);
        out_end        = (addr_q == last_q);
    end

    assign buffer_pointer = ptr_q;
    assign frame_pap      = pap_q;
    assign length_error   = lerr_q;

    udp_ts_tx_out_reg u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (out_load),
        .data_i  (buffer_readdata),
        .start_i (out_start),
        .end_i   (out_end),
        .ready_i (payload_out_ready),
        .valid_o (payload_out_valid),
        .data_o  (payload_out_data),
        .start_o (payload_out_start),
        .end_o   (payload_out_end)
    );

`ifdef TX_FRAME_COUNT_EN
    logic [31:0] frame_count_q, frame_count_d;
    logic [31:0] drop_count_q, drop_count_d;

    always_comb begin
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;
        if (consume && payload_out_end) frame_count_d = frame_count_q + 32'd1;
        if (lerr_q) drop_count_d = drop_count_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign frame_count = frame_count_q;
    assign drop_count  = drop_count_q;
`else
    assign frame_count = '0;
    assign drop_count  = '0;
`endif

endmodule

// File: tb/tb_udp_ts_tx_dma.sv
// Directed self-checking bench for udp_ts_tx_dma with a frame-buffer and queue model.
// Covers full/short/dropped frames, backpressure, waitstates and mid-frame reset.
module tb_udp_ts_tx_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        unload;
    logic [1:0]  unload_pointer;
    logic        unload_ack;
    logic [1:0]  buffer_pointer;
    logic [7:0]  buffer_address;
    logic        buffer_read;
    logic [31:0] buffer_readdata;
    logic        buffer_readdatavalid;
    logic        buffer_waitrequest;
    logic        free;
    logic [1:0]  free_pointer;
    logic        free_ack;
    logic        payload_out_valid;
    logic        payload_out_start;
    logic        payload_out_end;
    logic [31:0] payload_out_data;
    logic        payload_out_ready;
    logic [31:0] frame_pap;
    logic        length_error;
    logic [31:0] frame_count;
    logic [31:0] drop_count;

    int checks = 0;
    int failures = 0;

    // Bench-controlled stimulus knobs
    logic [1:0]  offer_ptr = 2'd0;
    logic [31:0] param_word = 32'd0;
    int          offer_req = 0;
    logic        ready_mode = 1'b0;
    logic        stall_en = 1'b0;
    logic [3:0]  rpat = 4'b1001;

    // Model / monitor state
    int          offer_done = 0;
    int          cyc = 0;
    logic [1:0]  ws_cnt = 2'd0;
    logic [33:0] acc_mem [0:1023];
    int          acc_cnt = 0;
    int          lerr_cnt = 0;
    int          valid_cnt = 0;
    int          stall_cnt = 0;
    int          ack_cyc = 0;
    int          start_cyc = 0;
    logic        prev_vs = 1'b0;
    logic        hold_prev = 1'b0;
    logic [34:0] hold_val = '0;
    logic        stall_prev = 1'b0;
    logic [7:0]  addr_prev = '0;

    udp_ts_tx_dma dut (
        .clk                  (clk),
        .rst                  (rst),
        .unload               (unload),
        .unload_pointer       (unload_pointer),
        .unload_ack           (unload_ack),
        .buffer_pointer       (buffer_pointer),
        .buffer_address       (buffer_address),
        .buffer_read          (buffer_read),
        .buffer_readdata      (buffer_readdata),
        .buffer_readdatavalid (buffer_readdatavalid),
        .buffer_waitrequest   (buffer_waitrequest),
        .free                 (free),
        .free_pointer         (free_pointer),
        .free_ack             (free_ack),
        .payload_out_valid    (payload_out_valid),
        .payload_out_start    (payload_out_start),
        .payload_out_end      (payload_out_end),
        .payload_out_data     (payload_out_data),
        .payload_out_ready    (payload_out_ready),
        .frame_pap            (frame_pap),
        .length_error         (length_error),
        .frame_count          (frame_count),
        .drop_count           (drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [1:0] ptr, input int addr);
        return {8'hA5, 6'd0, ptr, 8'h00, 8'(addr)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    assign unload_pointer     = offer_ptr;
    assign unload_ack         = unload && (offer_req != offer_done);
    assign free_ack           = free;
    assign buffer_waitrequest = stall_en && buffer_read && ws_cnt != 2'd3 &&
                                (buffer_address == 8'd50 || buffer_address == 8'd5);

    // Frame buffer with one-cycle read latency, upstream queue and ready pattern
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            buffer_readdatavalid <= 1'b0;
            buffer_readdata      <= '0;
            payload_out_ready    <= 1'b1;
            ws_cnt               <= 2'd0;
        end else begin
            buffer_readdatavalid <= buffer_read && !buffer_waitrequest;
            buffer_readdata      <= (buffer_address == 8'd50) ? param_word
                                    : word_of(buffer_pointer, int'(buffer_address));
            payload_out_ready    <= ready_mode ? rpat[cyc[1:0]] : 1'b1;
            if (buffer_waitrequest) ws_cnt <= ws_cnt + 2'd1;
            else if (buffer_read) ws_cnt <= 2'd0;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (unload && unload_ack) offer_done <= offer_done + 1;
    end

    // Monitor: scoreboard capture plus per-cycle protocol checks
    always @(negedge clk) begin
        if (rst) begin
            prev_vs    <= 1'b0;
            hold_prev  <= 1'b0;
            stall_prev <= 1'b0;
        end else begin
            if (payload_out_valid && payload_out_ready) begin
                acc_mem[acc_cnt] <= {payload_out_start, payload_out_end, payload_out_data};
                acc_cnt <= acc_cnt + 1;
            end
            if (payload_out_valid) valid_cnt <= valid_cnt + 1;
            if (length_error) lerr_cnt <= lerr_cnt + 1;
            if (buffer_waitrequest) stall_cnt <= stall_cnt + 1;
            if (unload && unload_ack) ack_cyc <= cyc;
            if (payload_out_valid && payload_out_start && !prev_vs) start_cyc <= cyc;
            prev_vs <= payload_out_valid && payload_out_start;
            if (hold_prev)
                chk("hold_stable", 64'({payload_out_valid, payload_out_start, payload_out_end,
                    payload_out_data}), 64'(hold_val));
            if (payload_out_valid && !payload_out_ready)
                chk("no_read_full", 64'(buffer_read), 64'(0));
            if (stall_prev)
                chk("stall_hold", 64'({buffer_read, buffer_address}), 64'({1'b1, addr_prev}));
            hold_prev  <= payload_out_valid && !payload_out_ready;
            hold_val   <= {payload_out_valid, payload_out_start, payload_out_end,
                           payload_out_data};
            stall_prev <= buffer_waitrequest;
            addr_prev  <= buffer_address;
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, 64'({unload, buffer_read, free, payload_out_valid,
            payload_out_start, payload_out_end, length_error}), 64'(0));
        chk({tag, "_ptr_addr"}, 64'({buffer_pointer, free_pointer, buffer_address}), 64'(0));
        chk({tag, "_data"}, 64'(payload_out_data), 64'(0));
        chk({tag, "_pap"}, 64'(frame_pap), 64'(0));
        chk({tag, "_cnt"}, {frame_count, drop_count}, 64'(0));
    endtask

    task automatic run_frame(input logic [1:0] ptr, input logic [31:0] param, input int n);
        int base, lerr0, val0;
        logic ok;
        base  = acc_cnt;
        lerr0 = lerr_cnt;
        val0  = valid_cnt;
        offer_ptr  = ptr;
        param_word = param;
        offer_req++;
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(posedge clk);
            #1;
            if (free) ok = 1'b1;
        end
        chk("free_seen", 64'(ok), 64'(1));
        chk("free_ptr", 64'(free_pointer), 64'(ptr));
        chk("pap", 64'(frame_pap), 64'(param));
        chk("nwords", 64'(acc_cnt - base), 64'(n));
        for (int i = 0; i < n; i++)
            chk("word", 64'(acc_mem[base + i]), 64'({(i == 0), (i == n - 1), word_of(ptr, i)}));
        @(posedge clk);
        #1;
        if (n == 0) begin
            chk("lerr_pulse", 64'(lerr_cnt - lerr0), 64'(1));
            chk("drop_no_valid", 64'(valid_cnt - val0), 64'(0));
        end else begin
            chk("no_lerr", 64'(lerr_cnt - lerr0), 64'(0));
            chk("latency_ge4", 64'((start_cyc - ack_cyc) >= 4), 64'(1));
        end
    endtask

    initial begin
        logic found;
        #1;
        check_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        run_frame(2'd2, 32'h00AB_002F, 47);
        ready_mode = 1'b1;
        run_frame(2'd2, 32'h00AB_002F, 47);
        ready_mode = 1'b0;
        run_frame(2'd1, 32'h00AB_0000, 0);
        run_frame(2'd3, 32'h00AB_0030, 0);
        run_frame(2'd0, 32'h00CD_0001, 1);

        stall_en = 1'b1;
        begin
            int s0;
            s0 = stall_cnt;
            run_frame(2'd0, 32'h0077_0008, 8);
            chk("stall_cycles", 64'(stall_cnt - s0), 64'(6));
        end
        stall_en = 1'b0;

`ifdef TX_FRAME_COUNT_EN
        chk("frame_count", 64'(frame_count), 64'(4));
        chk("drop_count", 64'(drop_count), 64'(2));
`else
        chk("frame_count_off", 64'(frame_count), 64'(0));
        chk("drop_count_off", 64'(drop_count), 64'(0));
`endif

        // Reset while the read of word 10 is outstanding
        offer_ptr  = 2'd1;
        param_word = 32'h00AB_002F;
        offer_req++;
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(posedge clk);
            #1;
            if (buffer_read && buffer_address == 8'd10 && !buffer_waitrequest) found = 1'b1;
        end
        chk("word10_read_seen", 64'(found), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_zero("midreset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_frame(2'd3, 32'h00EE_0003, 3);
`ifdef TX_FRAME_COUNT_EN
        chk("frame_count_after_rst", 64'(frame_count), 64'(1));
`else
        chk("frame_count_after_rst", 64'(frame_count), 64'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/udp_ts_tx_dma.md
Name: udp_ts_tx_dma

Overview:
Transmit-side DMA for the TS frame buffer. It takes filled-buffer pointers from the receive queue and reads each frame's parameter word to get its length and mapped PAP. It then streams the payload words out as a 32-bit valid/start/end stream with ready backpressure, and returns the pointer to the free pool. It sits between the frame buffer read port and the downstream UDP/TS packetiser.

Parameters:
P_POINTER_WIDTH, 2, width of buffer pointer
P_BUFFER_ADDRESS_BITS, 8, word address width within one buffer
P_BUFFER_PARAMETER_WORD, 50, word location of the frame parameter word
P_MAX_WORDS, 47, maximum payload words per frame (188-byte TS)

Ports:
clk  in  1  clock
rst  in  1  reset
unload  out  1  request next queued pointer
unload_pointer  in  P_POINTER_WIDTH  queued pointer
unload_ack  in  1  pointer valid, completes unload
buffer_pointer  out  P_POINTER_WIDTH  buffer select
buffer_address  out  P_BUFFER_ADDRESS_BITS  word address
buffer_read  out  1  Avalon read
buffer_readdata  in  32  read data
buffer_readdatavalid  in  1  read data valid
buffer_waitrequest  in  1  stall
free  out  1  return pointer to free pool
free_pointer  out  P_POINTER_WIDTH  pointer returned
free_ack  in  1  return accepted
payload_out_valid  out  1  word valid
payload_out_start  out  1  first word of frame
payload_out_end  out  1  last word of frame
payload_out_data  out  32  payload word
payload_out_ready  in  1  downstream accepts
frame_pap  out  32  parameter word of current frame, stable from start to end
length_error  out  1  one-cycle pulse: frame dropped for bad length
frame_count  out  32  frames sent (feature)
drop_count  out  32  frames dropped (feature)

Behaviour:
- Reset is `rst`, asynchronous, active-high; clock is `clk`.
- Reset values: all outputs 0 (addresses, pointers, data, counters included).
- States:
  - S_IDLE: if no free return is pending, assert unload → S_UNLOAD.
  - S_UNLOAD: hold unload until unload_ack. Latch the pointer and drive buffer_pointer; deassert unload the same cycle → S_RD_PARAM.
  - S_RD_PARAM: read = 1 at address P_BUFFER_PARAMETER_WORD. Held while waitrequest; waitrequest low → read drops → S_WAIT_PARAM.
  - S_WAIT_PARAM: on readdatavalid, latch frame_pap = readdata. Word count n = readdata[7:0]; 0 or > P_MAX_WORDS → pulse length_error, → S_RELEASE; else address = 0 → S_RD_DATA.
  - S_RD_DATA: issue a read only if the output register is empty or is being consumed this cycle (payload_out_valid & payload_out_ready). Otherwise wait. Accepted read → S_WAIT_DATA.
  - S_WAIT_DATA: on readdatavalid, load the output register: valid = 1, start = (address == 0), end = (address == n-1). If not last, address+1 → S_RD_DATA; if last → S_DRAIN.
  - S_DRAIN: wait until the last word is accepted → S_RELEASE.
  - S_RELEASE: free = 1, free_pointer = latched pointer; hold until free_ack → S_IDLE.
- At most one outstanding read. readdatavalid outside S_WAIT_PARAM/S_WAIT_DATA is ignored.
- Output register holds data/start/end stable while valid & ~ready. valid drops on the accepting cycle unless new data loads in the same cycle.
- n = 1: start and end asserted together on one word.
- Latency: unload_ack to first payload_out_valid is ≥4 cycles with zero waitstates and 1-cycle read latency.
- No pointer is ever lost: dropped frames still pass through S_RELEASE.
- Reset mid-frame: all state is cleared. Re-queueing the in-flight pointer is not this block's job.

Optional Feature:
- Macro: TX_FRAME_COUNT_EN.
- Defined:
  - frame_count increments when a word with end = 1 is accepted.
  - drop_count increments on each length_error.
  - Both are 32-bit and wrap at 2^32.
- Undefined: both ports tied to 0 and no counter registers are inferred.

Decomposition:
- Shared package: state encoding localparams, the parameter-word field positions (length [7:0]), and P_MAX_WORDS.
- One natural sub-module: udp_ts_tx_out_reg, a single-entry output register with valid/ready, start/end flags and load/consume logic.

Test Plan:
- Pointer 2, param word 0x00AB_002F (n = 47), no stalls → 47 words from addresses 0..46. Start on word 0, end on word 46. frame_pap = 0x00AB002F. free with pointer 2 after the last accept.
- Same frame, payload_out_ready toggled 1-0-0-1 → no loss or duplication. Data is held stable while stalled. No read is issued while the register is full and not consumed.
- Param length 0, then 48 → length_error pulses. No payload_out_valid. Pointer returned both times. drop_count = 2 with TX_FRAME_COUNT_EN.
- n = 1 → a single word with start = end = 1, then release.
- buffer_waitrequest high for 3 cycles on the parameter read and on data word 5 → read and address held. Output sequence is unchanged.
- rst asserted while in S_WAIT_DATA on word 10 → all outputs 0 immediately. The next frame runs cleanly from S_IDLE.
